frog_btn_conditioner: RTL

Input conditioning stage directly upstream of the frog position logic. Takes the four raw board push-buttons, synchronises and debounces each, and emits clean one-cycle, mutually exclusive move pulses in the clk domain. Supports optional hold-to-repeat so a held button steps the frog at a fixed rate. Downstream logic consumes only these pulses and never sees raw button levels.

---
 rtl/frog_pkg.sv | 29 ++
 rtl/frog_btn_channel.sv | 101 ++++++++++
 rtl/frog_btn_conditioner.sv | 85 ++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// Shared definitions for the frog button conditioning path: button indices,
// the fixed arbitration order and the default debounce/repeat timing.
package frog_pkg;

    typedef enum logic [1:0] {
        BTN_UP    = 2'd0,
        BTN_DOWN  = 2'd1,
        BTN_LEFT  = 2'd2,
        BTN_RIGHT = 2'd3
    } btn_e;

    localparam int NUM_BTNS = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Arbitration order, highest priority first: down, up, right, left.
    function automatic btn_e prioBtn(input int rank);
        case (rank)
            0:       return BTN_DOWN;
            1:       return BTN_UP;
            2:       return BTN_RIGHT;
            default: return BTN_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/frog_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, rising-edge
// detect on the debounced level and the hold-to-repeat timer.
import frog_pkg::*;

module frog_btn_channel #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_event
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_levelPrev;
    logic [DB_W-1:0]  r_dbCnt;
    logic [RPT_W-1:0] r_rptCnt;
    logic             r_rptFirst;

    logic             w_press;
    logic             w_rptHit;
    logic             w_repeat;

    assign w_press  = r_level & ~r_levelPrev;
    assign w_rptHit = (r_rptCnt == (r_rptFirst ? RPT_DELAY_C : RPT_PERIOD_C));
    assign w_repeat = (REPEAT_EN != 0) && r_level && (r_rptCnt != '0) && w_rptHit;

    // Bring the asynchronous button into the clk domain; only r_sync2 is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_dbCnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_dbCnt <= '0;
        end else if (r_dbCnt == DB_LAST) begin
            r_level <= ~r_level;
            r_dbCnt <= '0;
        end else begin
            r_dbCnt <= r_dbCnt + DB_W'(1);
        end
    end

    // Remember last cycle's debounced level so a 0->1 step gives one press strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_levelPrev <= 1'b0;
        end else begin
            r_levelPrev <= r_level;
        end
    end

    // Repeat timer: counts cycles since the last event, idle (0) while released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptCnt   <= '0;
            r_rptFirst <= 1'b0;
        end else if (!r_level || (REPEAT_EN == 0)) begin
            r_rptCnt   <= '0;
            r_rptFirst <= 1'b0;
        end else if (w_press) begin
            r_rptCnt   <= RPT_W'(1);
            r_rptFirst <= 1'b1;
        end else if (r_rptCnt != '0) begin
            if (w_rptHit) begin
                r_rptCnt   <= RPT_W'(1);
                r_rptFirst <= 1'b0;
            end else begin
                r_rptCnt <= r_rptCnt + RPT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_event = w_press | w_repeat;

endmodule

// File: rtl/frog_btn_conditioner.sv
// Top of the button conditioner: four debounced channels feeding a fixed
// priority arbiter, enable gating and registered one-cycle move pulses.
import frog_pkg::*;

module frog_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    output logic       btnUp,
    output logic       btnDown,
    output logic       btnLeft,
    output logic       btnRight,
    output logic       move,
    output logic [3:0] held
);

    logic [NUM_BTNS-1:0] w_raw;
    logic [NUM_BTNS-1:0] w_level;
    logic [NUM_BTNS-1:0] w_event;
    logic [NUM_BTNS-1:0] w_grant;

    logic [NUM_BTNS-1:0] r_pulse;
    logic                r_move;
    logic [NUM_BTNS-1:0] r_held;

    assign w_raw = {btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        frog_btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g]),
            .o_event (w_event[g])
        );
    end

    // Grant the single highest-priority event this cycle; losers are simply dropped.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if ((w_grant == '0) && w_event[prioBtn(i)]) begin
                w_grant[prioBtn(i)] = 1'b1;
            end
        end
        if (!en) begin
            w_grant = '0;
        end
    end

    // Register pulses, move and levels together so they line up at the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse <= '0;
            r_move  <= 1'b0;
            r_held  <= '0;
        end else begin
            r_pulse <= w_grant;
            r_move  <= |w_grant;
            r_held  <= w_level;
        end
    end

    assign btnUp    = r_pulse[BTN_UP];
    assign btnDown  = r_pulse[BTN_DOWN];
    assign btnLeft  = r_pulse[BTN_LEFT];
    assign btnRight = r_pulse[BTN_RIGHT];
    assign move     = r_move;
    assign held     = r_held;

endmodule
